// File: rtl/rx_deformatter.sv
// Link receiver: locks to the trailer (comma, CRC, link ID, comma run) and
// reassembles six-word payload frames tagged with their BX number.
module rx_deformatter #(
  parameter int COMMA_RUN_LEN = 27,
  parameter int BX_TRAILER    = 3555,
  parameter int BX_FIRST      = 3560,
  parameter int BX_MAX        = 3563
) (
  input  logic             clk_250,
  input  logic             rst_n,
  input  logic [31:0]      rxdata,
  input  logic [3:0]       rxcharisk,
  output logic [2:0][63:0] frame_data,
  output logic             frame_valid,
  output logic [11:0]      frame_bxn,
  output logic [19:0]      link_id,
  output logic             link_id_valid,
  output logic [31:0]      crc_rx,
  output logic             crc_valid,
  output logic             aligned,
  output logic             err,
  output logic [15:0]      err_cnt
);

  localparam logic [31:0] COMMA_WORD = 32'h505050BC;
  localparam logic [31:0] PAD_WORD   = 32'hF7F7F7F7;

  typedef enum logic [2:0] {
    HUNT, TRL_CRC, TRL_LID, TRL_END, COMMA_RUN, PAYLOAD
  } state_t;

  state_t      state, state_next;
  logic [5:0]  comma_cnt;
  logic [2:0]  word_idx;
  logic [11:0] bx_next;
  logic [31:0] words [5];

  logic is_comma, is_pad, is_data, lid_ok;
  logic err_evt, crc_load, lid_load, lock, cnt_inc, first_word, pay_store, frame_done;

  assign is_comma   = (rxdata == COMMA_WORD) && (rxcharisk == 4'b0001);
  assign is_pad     = (rxdata == PAD_WORD) && (rxcharisk == 4'hF);
  assign is_data    = (rxcharisk == 4'h0);
  assign lid_ok     = is_data && (rxdata[31:26] == 6'd0) && (rxdata[15:10] == 6'd0);
  assign frame_done = pay_store && (word_idx == 3'd5);

  always_comb begin
    state_next = state;
    err_evt    = 1'b0;
    crc_load   = 1'b0;
    lid_load   = 1'b0;
    lock       = 1'b0;
    cnt_inc    = 1'b0;
    first_word = 1'b0;
    pay_store  = 1'b0;
    // Pads are invisible: no state, counter or error effect anywhere.
    if (!is_pad) begin
      case (state)
        HUNT: begin
          if (is_comma) state_next = TRL_CRC;
        end
        TRL_CRC: begin
          if (is_data) begin
            crc_load   = 1'b1;
            state_next = TRL_LID;
          end else if (!is_comma) begin
            err_evt = 1'b1;
          end
        end
        TRL_LID: begin
          if (lid_ok) begin
            lid_load   = 1'b1;
            state_next = TRL_END;
          end else begin
            err_evt = 1'b1;
          end
        end
        TRL_END: begin
          if (is_comma) begin
            lock       = 1'b1;
            state_next = COMMA_RUN;
          end else begin
            err_evt = 1'b1;
          end
        end
        COMMA_RUN: begin
          if (is_comma) begin
            cnt_inc = 1'b1;
          end else if (is_data && (comma_cnt == 6'(COMMA_RUN_LEN))) begin
            first_word = 1'b1;
            state_next = PAYLOAD;
          end else begin
            err_evt = 1'b1;
          end
        end
        PAYLOAD: begin
          if (is_data) begin
            pay_store = 1'b1;
          end else if (is_comma && (word_idx == 3'd0) && (bx_next == 12'(BX_TRAILER))) begin
            state_next = TRL_CRC;
          end else begin
            err_evt = 1'b1;
          end
        end
        default: state_next = HUNT;
      endcase
    end
    if (err_evt) state_next = HUNT;
  end

  always_ff @(posedge clk_250 or negedge rst_n) begin
    if (!rst_n) begin
      state         <= HUNT;
      aligned       <= 1'b0;
      link_id_valid <= 1'b0;
      frame_valid   <= 1'b0;
      crc_valid     <= 1'b0;
      err           <= 1'b0;
      err_cnt       <= '0;
      link_id       <= '0;
      crc_rx        <= '0;
      frame_data    <= '0;
      frame_bxn     <= '0;
      comma_cnt     <= '0;
      word_idx      <= '0;
      bx_next       <= '0;
      for (int i = 0; i < 5; i++) words[i] <= '0;
    end else begin
      state       <= state_next;
      frame_valid <= 1'b0;
      crc_valid   <= 1'b0;
      err         <= 1'b0;
      if (crc_load) begin
        crc_rx    <= rxdata;
        crc_valid <= 1'b1;
      end
      if (lid_load) link_id <= {rxdata[25:16], rxdata[9:0]};
      if (lock) begin
        aligned       <= 1'b1;
        link_id_valid <= 1'b1;
        comma_cnt     <= 6'd1;
      end
      if (cnt_inc && (comma_cnt != 6'd63)) comma_cnt <= comma_cnt + 6'd1;
      if (first_word) begin
        words[0] <= rxdata;
        word_idx <= 3'd1;
        bx_next  <= 12'(BX_FIRST);
      end
      if (pay_store) begin
        if (frame_done) begin
          // The published frame only changes here, so a dropped partial frame never leaks out.
          frame_data  <= {rxdata, words[4], words[3], words[2], words[1], words[0]};
          frame_valid <= 1'b1;
          frame_bxn   <= bx_next;
          bx_next     <= (bx_next == 12'(BX_MAX)) ? 12'd0 : bx_next + 12'd1;
          word_idx    <= 3'd0;
        end else begin
          for (int i = 0; i < 5; i++) begin
            if (word_idx == 3'(i)) words[i] <= rxdata;
          end
          word_idx <= word_idx + 3'd1;
        end
      end
      if (err_evt) begin
        err      <= 1'b1;
        aligned  <= 1'b0;
        word_idx <= 3'd0;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
    end
  end

endmodule
